gray_counter_scan7seg: RTL and testbench

// - Up/down WIDTH-bit counter with a binary and a reflected-Gray view, plus a time-multiplexed

---
 rtl/gray_counter_scan7seg_if.sv | 28 ++
 rtl/gray_counter_scan7seg.sv | 105 ++++++++++
 tb/tb_gray_counter_scan7seg.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gray_counter_scan7seg_if.sv
// Control/status bundle for the Gray counter with multiplexed hex display.
// The master drives count controls; the slave returns count views and display drive.
interface gray_counter_scan7seg_if #(
  parameter int WIDTH = 8
);
  localparam int NDIG = WIDTH / 4;

  logic             step;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             mode;
  logic [WIDTH-1:0] count_out;
  logic [WIDTH-1:0] gray_out;
  logic             wrap;
  logic [6:0]       seg_out;
  logic [NDIG-1:0]  an_out;

  modport master (
    output step, up_dn, load, load_val, mode,
    input  count_out, gray_out, wrap, seg_out, an_out
  );

  modport slave (
    input  step, up_dn, load, load_val, mode,
    output count_out, gray_out, wrap, seg_out, an_out
  );
endinterface

// File: rtl/gray_counter_scan7seg.sv
// Up/down binary counter with a reflected-Gray view and a time-multiplexed
// active-low hex 7-segment driver, one digit per nibble of the count.
module gray_counter_scan7seg #(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 50000
) (
  input logic               clk,
  input logic               rst,
  gray_counter_scan7seg_if.slave bus
);
  localparam int NDIG = WIDTH / 4;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [DIVW-1:0]  DIV_LOAD = DIVW'(SCAN_DIV - 1);
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NDIG - 1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] disp_src;
  logic             wrap_q;
  logic [DIVW-1:0]  div_q;
  logic [IDXW-1:0]  idx_q;
  logic [IDXW-1:0]  idx_next;
  logic [3:0]       nib;
  logic [6:0]       seg_next;
  logic [6:0]       seg_q;
  logic [NDIG-1:0]  an_q;

  assign gray = cnt ^ (cnt >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wrap_q <= 1'b0;
    end else if (bus.load) begin
      cnt    <= bus.load_val;
      wrap_q <= 1'b0;
    end else if (bus.step) begin
      if (bus.up_dn) begin
        cnt    <= cnt + WIDTH'(1);
        wrap_q <= (cnt == CNT_MAX);
      end else begin
        cnt    <= cnt - WIDTH'(1);
        wrap_q <= (cnt == '0);
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // Dwell timer is a down-counter; terminal count advances the digit.
  always_comb begin
    idx_next = idx_q;
    if (div_q == '0) begin
      idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
    end
  end

  // Decode the digit being selected this edge so anode and segments switch together.
  always_comb begin
    disp_src = bus.mode ? gray : cnt;
    nib      = 4'(disp_src >> {idx_next, 2'b00});
    seg_next = 7'h7F;
    case (nib)
      4'h0: seg_next = 7'h40;
      4'h1: seg_next = 7'h79;
      4'h2: seg_next = 7'h24;
      4'h3: seg_next = 7'h30;
      4'h4: seg_next = 7'h19;
      4'h5: seg_next = 7'h12;
      4'h6: seg_next = 7'h02;
      4'h7: seg_next = 7'h78;
      4'h8: seg_next = 7'h00;
      4'h9: seg_next = 7'h10;
      4'hA: seg_next = 7'h08;
      4'hB: seg_next = 7'h03;
      4'hC: seg_next = 7'h46;
      4'hD: seg_next = 7'h21;
      4'hE: seg_next = 7'h06;
      4'hF: seg_next = 7'h0E;
      default: seg_next = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_LOAD;
      idx_q <= '0;
      an_q  <= ~NDIG'(1);
      seg_q <= 7'h40;
    end else begin
      div_q <= (div_q == '0) ? DIV_LOAD : div_q - DIVW'(1);
      idx_q <= idx_next;
      an_q  <= ~(NDIG'(1) << idx_next);
      seg_q <= seg_next;
    end
  end

  assign bus.count_out = cnt;
  assign bus.gray_out  = gray;
  assign bus.wrap      = wrap_q;
  assign bus.seg_out   = seg_q;
  assign bus.an_out    = an_q;
endmodule

// File: tb/tb_gray_counter_scan7seg.sv
// Directed bench for gray_counter_scan7seg (WIDTH=8, SCAN_DIV=4) with a
// reference model feeding an expectation queue drained after each clock edge.
module tb_gray_counter_scan7seg;
  localparam int WIDTH    = 8;
  localparam int SCAN_DIV = 4;
  localparam int NDIG     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gray_counter_scan7seg_if #(.WIDTH(WIDTH)) bus ();

  gray_counter_scan7seg #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef enum {S_CNT, S_GRAY, S_WRAP, S_AN, S_SEG} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_cnt;
  logic       m_wrap;
  int         m_div;
  int         m_idx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge, queue its predictions, clock the DUT, then compare.
  task automatic cyc();
    logic [7:0] prev;
    logic [7:0] src;
    logic [6:0] s;
    logic [1:0] a;
    exp_t       e;
    prev = m_cnt;
    if (rst) begin
      m_cnt  = 8'h00;
      m_wrap = 1'b0;
      m_div  = 0;
      m_idx  = 0;
      s      = 7'h40;
    end else begin
      if (bus.load) begin
        m_cnt  = bus.load_val;
        m_wrap = 1'b0;
      end else if (bus.step) begin
        if (bus.up_dn) begin
          m_wrap = (prev == 8'hFF);
          m_cnt  = prev + 8'd1;
        end else begin
          m_wrap = (prev == 8'h00);
          m_cnt  = prev - 8'd1;
        end
      end else begin
        m_wrap = 1'b0;
      end
      if (m_div == SCAN_DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % NDIG;
      end else begin
        m_div++;
      end
      src = bus.mode ? (prev ^ (prev >> 1)) : prev;
      s   = hex7((m_idx == 1) ? src[7:4] : src[3:0]);
    end
    a = ~(2'(1) << m_idx);
    sb.push_back('{S_CNT,  32'(m_cnt)});
    sb.push_back('{S_GRAY, 32'(m_cnt ^ (m_cnt >> 1))});
    sb.push_back('{S_WRAP, 32'(m_wrap)});
    sb.push_back('{S_AN,   32'(a)});
    sb.push_back('{S_SEG,  32'(s)});
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        S_CNT:   check("count_out", 32'(bus.count_out), e.val);
        S_GRAY:  check("gray_out",  32'(bus.gray_out),  e.val);
        S_WRAP:  check("wrap",      32'(bus.wrap),      e.val);
        S_AN:    check("an_out",    32'(bus.an_out),    e.val);
        default: check("seg_out",   32'(bus.seg_out),   e.val);
      endcase
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    logic [7:0] prev_g;
    int         n;

    // Reset held with load and step active
    bus.step     = 1'b1;
    bus.up_dn    = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 8'h77;
    bus.mode     = 1'b0;
    rst          = 1'b1;
    repeat (3) cyc();
    check("rst_count", 32'(bus.count_out), 32'h00);
    check("rst_an",    32'(bus.an_out),    32'h2);
    check("rst_seg",   32'(bus.seg_out),   32'h40);
    rst      = 1'b0;
    bus.load = 1'b0;
    bus.step = 1'b0;
    cyc();

    // Full up-count through wrap
    bus.step  = 1'b1;
    bus.up_dn = 1'b1;
    prev_g    = bus.gray_out;
    for (int i = 0; i < 256; i++) begin
      cyc();
      check("gray_1bit", 32'($countones(bus.gray_out ^ prev_g)), 32'd1);
      prev_g = bus.gray_out;
    end
    check("wrap_up", 32'(bus.wrap), 32'd1);
    bus.step = 1'b0;
    cyc();

    // Load zero then step down
    bus.load     = 1'b1;
    bus.load_val = 8'h00;
    cyc();
    bus.load  = 1'b0;
    bus.step  = 1'b1;
    bus.up_dn = 1'b0;
    cyc();
    check("down_count", 32'(bus.count_out), 32'hFF);
    check("down_gray",  32'(bus.gray_out),  32'h80);
    check("down_wrap",  32'(bus.wrap),      32'd1);
    bus.step = 1'b0;
    cyc();

    // Load of the max value must not flag wrap
    bus.load     = 1'b1;
    bus.load_val = 8'hFF;
    cyc();
    bus.load = 1'b0;

    // Direction flipping every step across the wrap point
    bus.step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.up_dn = (i % 2 == 0);
      cyc();
    end
    bus.step = 1'b0;
    cyc();

    // Load beats a simultaneous step
    bus.load     = 1'b1;
    bus.load_val = 8'h5A;
    bus.step     = 1'b1;
    bus.up_dn    = 1'b1;
    cyc();
    check("prio_count", 32'(bus.count_out), 32'h5A);
    check("prio_wrap",  32'(bus.wrap),      32'd0);
    bus.load = 1'b0;
    bus.step = 1'b0;

    // Scan in binary then Gray display mode
    bus.load     = 1'b1;
    bus.load_val = 8'h3C;
    cyc();
    bus.load = 1'b0;
    repeat (10) cyc();
    bus.mode = 1'b1;
    repeat (10) cyc();
    check("gray_22_seg", 32'(bus.seg_out), 32'h24);

    // Reset in the middle of digit 1's dwell
    n = 0;
    while (m_idx != 1 && n < 8) begin
      cyc();
      n++;
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_an", 32'(bus.an_out), 32'h2);
    repeat (9) cyc();
    bus.mode = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
